// File: rtl/arith_pkg.sv
// Shared arithmetic constants and helpers for the multiplier, divider and
// averaging controller.
package arith_pkg;

    localparam int N_DEFAULT = 20;

    // Counter width able to hold the values 0..n (n iterations plus idle).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one partial product per clock,
// full 2N-bit result, start/ready/done handshake shared with the divider.
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           ready,
    output logic           done
);

    localparam int CW = cnt_width(N);

    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [2*N-1:0] acc_q,    acc_d;
    logic [N-1:0]   mcand_q,  mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic           done_q,   done_d;
    logic [N:0]     sum;

    // IDLE is cnt==0; any non-zero count means an operation is in flight.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done_d   = 1'b0;
        sum      = '0;

        if (start) begin
            cnt_d    = CW'(N);
            acc_d    = '0;
            mcand_d  = multiplicand;
            mplier_d = multiplier;
        end else if (cnt_q != '0) begin
            // Keep the carry in sum[N] so all-ones operands cannot overflow.
            sum      = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
            acc_d    = {sum, acc_q[N-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            done_d   = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            done_q   <= done_d;
        end
    end

    assign product = acc_q;
    assign ready   = (cnt_q == '0);
    assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products are queued at start
// and retired on each done pulse.
module tb_seq_multiplier;

    localparam int N = 20;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic           ready;
    logic           done;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int ops_expected = 0;
    logic [63:0] expq[$];

    seq_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .ready        (ready),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; a start while busy abandons the pending expectation.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] ea, eb;
        if (!ready && expq.size() > 0) begin
            void'(expq.pop_back());
            ops_expected--;
        end
        ea = 64'(a);
        eb = 64'(b);
        expq.push_back(ea * eb);
        ops_expected++;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        tick();
        start        = 1'b0;
        multiplicand = $urandom();
        multiplier   = $urandom();
    endtask

    // Returns the number of cycles ready stayed low, bounded at 100.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) check_val("ready_timeout", 64'(n), 64'(N));
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (expq.size() == 0) begin
                check_val("unexpected_done", 64'(1), 64'(0));
            end else begin
                check_val("sb_product", 64'(product), expq.pop_front());
            end
        end
    end

    initial begin
        int n;
        int idle_bad;
        logic [N-1:0] ra, rb;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check_val("rst_ready",   64'(ready),   64'(1));
        check_val("rst_done",    64'(done),    64'(0));
        check_val("rst_product", 64'(product), 64'(0));
        rst = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            multiplicand = $urandom();
            multiplier   = $urandom();
            tick();
            if (ready !== 1'b1 || done !== 1'b0 || product !== '0) idle_bad++;
        end
        check_val("idle_quiet", 64'(idle_bad), 64'(0));

        // Basic 3*5
        start_op(20'd3, 20'd5);
        wait_ready(n);
        check_val("basic_cycles",  64'(n),       64'(N));
        check_val("basic_done",    64'(done),    64'(1));
        check_val("basic_product", 64'(product), 64'd15);
        tick();
        check_val("basic_done_pulse", 64'(done),    64'(0));
        check_val("basic_hold",       64'(product), 64'd15);

        // All-ones operands keep the top carry
        start_op(20'hFFFFF, 20'hFFFFF);
        wait_ready(n);
        check_val("max_cycles",  64'(n),       64'(N));
        check_val("max_product", 64'(product), 64'hFF_FFE0_0001);
        tick();

        // Zero operand still takes the full count
        start_op(20'h12345, 20'h0);
        wait_ready(n);
        check_val("zero_cycles",  64'(n),       64'(N));
        check_val("zero_done",    64'(done),    64'(1));
        check_val("zero_product", 64'(product), 64'(0));
        tick();

        // Restart while busy
        start_op(20'd7, 20'd9);
        repeat (7) tick();
        check_val("restart_busy", 64'(ready), 64'(0));
        start_op(20'd2, 20'd11);
        wait_ready(n);
        check_val("restart_cycles",  64'(n),       64'(N));
        check_val("restart_product", 64'(product), 64'd22);
        tick();

        // Reset mid-operation
        start_op(20'd100, 20'd100);
        repeat (9) tick();
        rst = 1'b1;
        expq.delete();
        ops_expected--;
        tick();
        rst = 1'b0;
        check_val("midrst_ready",   64'(ready),   64'(1));
        check_val("midrst_product", 64'(product), 64'(0));
        check_val("midrst_done",    64'(done),    64'(0));
        tick();
        check_val("midrst_nodone",  64'(done),    64'(0));

        // Back-to-back: next start lands on the done cycle
        start_op(20'd6, 20'd7);
        wait_ready(n);
        check_val("b2b_first_done",    64'(done),    64'(1));
        check_val("b2b_first_product", 64'(product), 64'd42);
        start_op(20'd8, 20'd8);
        check_val("b2b_no_bubble", 64'(ready), 64'(0));
        wait_ready(n);
        check_val("b2b_cycles",  64'(n),       64'(N));
        check_val("b2b_product", 64'(product), 64'd64);

        // Random operands with 0-3 cycle gaps
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            ra = $urandom();
            rb = $urandom();
            if (i % 50 == 0) ra = '1;
            start_op(ra, rb);
            wait_ready(n);
            if (n != N) check_val("rand_cycles", 64'(n), 64'(N));
        end
        tick();
        tick();

        check_val("sb_drained", 64'(expq.size()), 64'(0));
        check_val("done_count", 64'(done_seen),   64'(ops_expected));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
